inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch initiator for the byte-addressed, combinational-read instruction memory. Owns the program counter, drives the memory's 32-bit byte address, captures the returned 32-bit little-endian word together with its PC into a small prefetch queue, and presents instructions to decode through a valid/ready handshake. A redirect input (branch/jump/trap) flushes the queue and restarts fetch at a new target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- inst_addr  output  32  byte address to instruction memory; always equals pc_q
- inst_i  input  32  instruction word returned combinationally for inst_addr in the same cycle
- redirect_valid  input  1  single-cycle request to restart fetch
- redirect_pc  input  32  restart target; bits [1:0] ignored (forced to 0)
- out_valid  output  1  queue head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_pc  output  32  PC of queue head
- out_inst  output  32  instruction of queue head
- occupancy  output  $clog2(DEPTH)+1  number of valid entries (debug/verification)

## Operation
- State: pc_q (32), circular buffer of DEPTH entries {pc, inst}, rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap mod DEPTH), count.
- Reset (async, any time, including mid-operation): pc_q ← RESET_PC, rd_ptr = wr_ptr = 0, count = 0. Outputs during/after reset: out_valid 0, out_pc 0, out_inst 0, occupancy 0, inst_addr = RESET_PC.
- pop = out_valid & out_ready. push = !redirect_valid & (count < DEPTH | pop).
- On push: entry[wr_ptr] ← {pc_q, inst_i}; wr_ptr+1; pc_q ← pc_q + 4 (wraps mod 2^32, 32'hFFFF_FFFC → 0).
- On pop: rd_ptr+1.
- count: +1 push only, −1 pop only, unchanged for push&pop or neither.
- Full (count == DEPTH) without pop: no push, pc_q holds, inst_addr holds.
- Full with pop: push and pop same edge, count stays DEPTH.
- Empty: out_ready ignored, no pop; push proceeds normally.
- Redirect (highest priority): at the edge, count ← 0, rd_ptr = wr_ptr = 0, pc_q ← {redirect_pc[31:2], 2'b00}; no push that cycle; a simultaneous pop is discarded (the handshake still completes from decode's view; the flushed instruction is considered killed by the redirecting stage).
- Back-to-back redirects: last one wins; each cancels the prior target before it is fetched.
- out_pc/out_inst: head entry when count > 0, else 0.
- No buffering of inst_i across cycles; the memory must be combinational.

## Timing
- Cycle 0 = first rising edge with rst low: pushes entry for RESET_PC; out_valid = 1 from cycle 1 with out_pc = RESET_PC.
- Steady state with out_ready held 1: one instruction per cycle, count stays 1, PCs strictly +4.
- Redirect asserted in cycle n: out_valid = 0 in cycle n+1 (inst_addr = target); target instruction at head with out_valid = 1 in cycle n+2. Redirect penalty: 2 cycles.
- With out_ready held 0 from reset: count reaches DEPTH after DEPTH edges, then fetch stalls; first out_ready=1 resumes push on the same edge.
- All outputs registered-state-derived; inst_addr has no combinational path from out_ready or redirect_valid.

## Test plan
- Reset release, ROM word at byte 0 = 32'h0000_0093, byte 4 = 32'h0010_0113, out_ready=1 -> cycle 1 out_pc=0/out_inst=32'h0000_0093, cycle 2 out_pc=4/out_inst=32'h0010_0113, occupancy=1.
- out_ready=0 for 10 cycles (DEPTH=4) -> occupancy 1,2,3,4,4…; inst_addr frozen at 16; then out_ready=1 -> heads 0,4,8,12,16 consecutively, no gaps or duplicates.
- Full queue, redirect_valid with redirect_pc=32'h0000_0043 while out_ready=1 -> next cycle occupancy 0, out_valid 0, inst_addr=32'h40; following cycle out_pc=32'h40.
- Redirects in two consecutive cycles to 32'h100 then 32'h200 -> no instruction from 32'h100 ever appears; head becomes 32'h200 two cycles after second redirect.
- RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted asynchronously mid-cycle with occupancy 3 -> out_valid and occupancy drop to 0 immediately; inst_addr=RESET_PC; fetch restarts normally after release.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: program counter, combinational-read imem request, prefetch queue to decode.
// Latency: an instruction is fetched on the edge that pushes it and is at the head on the following cycle.
//          A redirect costs 2 cycles before the target reaches the head.
// Backpressure: out_valid/out_ready handshake. A full queue stalls the PC unless the head pops on the same edge.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   inst_addr       - byte address to instruction memory (always pc_q)
//   inst_i          - word returned combinationally for inst_addr in the same cycle
//   redirect_valid  - single-cycle restart request; flushes the queue
//   redirect_pc     - restart target; bits [1:0] are forced to zero
//   out_valid       - queue head is valid
//   out_ready       - decode accepts the head
//   out_pc          - PC of the head (0 when empty)
//   out_inst        - instruction of the head (0 when empty)
//   occupancy       - number of valid queue entries
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                inst_addr,
    input  logic [31:0]                inst_i,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Architectural state
    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Queue storage; contents are only ever observed through count_q, so no reset is needed.
    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_inst_q [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    // The two low bits of the redirect target are dropped to keep fetch word aligned.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A head accepted in the same cycle as a redirect still completes the handshake;
    // the flush below simply overrides the pointer/count update.
    assign pop  = !empty && out_ready;
    // Full queue can still accept a new word when the head leaves on the same edge.
    assign push = !redirect_valid && (!full || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= pc_q;
            mem_inst_q[wr_ptr_q] <= inst_i;
        end
    end

    // All outputs come from registered state only; nothing here depends on
    // out_ready or redirect_valid combinationally.
    assign inst_addr = pc_q;
    assign out_valid = !empty;
    assign out_pc    = empty ? 32'd0 : mem_pc_q[rd_ptr_q];
    assign out_inst  = empty ? 32'd0 : mem_inst_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vectors against a small ROM model.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready directly.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  occupancy;

    // Second instance exercising address wrap from a high reset PC.
    logic        rst_w;
    logic [31:0] inst_addr_w;
    logic [31:0] inst_i_w;
    logic        out_valid_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_inst_w;
    logic [2:0]  occupancy_w;

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_i         (inst_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .occupancy      (occupancy)
    );

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst            (rst_w),
        .inst_addr      (inst_addr_w),
        .inst_i         (inst_i_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .out_valid      (out_valid_w),
        .out_ready      (1'b1),
        .out_pc         (out_pc_w),
        .out_inst       (out_inst_w),
        .occupancy      (occupancy_w)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd0)      return 32'h0000_0093;
        else if (a == 32'd4) return 32'h0010_0113;
        else                 return {a[15:0], ~a[15:0]};
    endfunction

    assign inst_i   = rom(inst_addr);
    assign inst_i_w = rom(inst_addr_w);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        rst_w          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_pc",    out_pc,         32'd0);
        check("rst_inst",  out_inst,       32'd0);
        check("rst_addr",  inst_addr,      32'd0);
        check("rst_addr_w", inst_addr_w,   32'hFFFF_FFF8);

        // Release with decode ready; empty queue ignores out_ready
        out_ready = 1'b1;
        rst       = 1'b0;
        step();
        check("c1_valid", 32'(out_valid), 32'd1);
        check("c1_pc",    out_pc,         32'd0);
        check("c1_inst",  out_inst,       32'h0000_0093);
        check("c1_addr",  inst_addr,      32'd4);
        step();
        check("c2_pc",    out_pc,         32'd4);
        check("c2_inst",  out_inst,       32'h0010_0113);
        check("c2_occ",   32'(occupancy), 32'd1);
        step();
        check("c3_pc",    out_pc,         32'd8);
        check("c3_occ",   32'(occupancy), 32'd1);

        // Fill with decode stalled
        rst = 1'b1;
        #1;
        out_ready = 1'b0;
        rst       = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("fill_occ%0d", k), 32'(occupancy), (k < 4) ? 32'(k) : 32'd4);
        end
        check("fill_addr", inst_addr, 32'd16);

        // Drain/refill: heads must be consecutive
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_pc%0d", i),   out_pc,   32'(4 * i));
            check($sformatf("drain_inst%0d", i), out_inst, rom(32'(4 * i)));
            step();
        end
        check("drain_occ", 32'(occupancy), 32'd4);
        check("drain_pc5", out_pc,         32'd20);

        // Redirect from full queue with pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        check("rd_occ",   32'(occupancy), 32'd0);
        check("rd_valid", 32'(out_valid), 32'd0);
        check("rd_addr",  inst_addr,      32'h40);
        check("rd_pc0",   out_pc,         32'd0);
        step();
        check("rd_pc",    out_pc,         32'h40);
        check("rd_inst",  out_inst,       rom(32'h40));
        check("rd_valid2", 32'(out_valid), 32'd1);

        // Back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check("bb1_valid", 32'(out_valid), 32'd0);
        check("bb1_addr",  inst_addr,      32'h100);
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("bb2_valid", 32'(out_valid), 32'd0);
        check("bb2_addr",  inst_addr,      32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bb_pc%0d", i), out_pc, 32'h200 + 32'(4 * i));
        end

        // Async reset mid-cycle with occupancy 3
        out_ready = 1'b0;
        step();
        step();
        check("ar_occ_pre", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("ar_occ",   32'(occupancy), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_addr",  inst_addr,      32'd0);
        out_ready = 1'b1;
        rst       = 1'b0;
        step();
        check("ar_pc0",   out_pc,   32'd0);
        check("ar_inst0", out_inst, 32'h0000_0093);
        step();
        check("ar_pc1",   out_pc,   32'd4);

        // Address wrap through 2^32
        rst_w = 1'b0;
        step();
        check("w_pc0", out_pc_w, 32'hFFFF_FFF8);
        step();
        check("w_pc1", out_pc_w, 32'hFFFF_FFFC);
        step();
        check("w_pc2",   out_pc_w,   32'h0000_0000);
        check("w_inst2", out_inst_w, 32'h0000_0093);
        check("w_occ",   32'(occupancy_w), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
